apb_cmd_master: RTL and testbench

APB_CMD_MASTER -- requirements
Module: apb_cmd_master

---
 rtl/apb_cmd_master.sv | 144 ++++++++++++++
 tb/tb_apb_cmd_master.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: single-command APB3 master bridging a valid/ready
// command port to a registered IDLE/SETUP/ACCESS/RESP transfer.
//
// Ports:
//   PCLK, PRESETn                  clock, synchronous active-low reset
//   cmd_valid/cmd_ready            command handshake (ready only in IDLE)
//   cmd_addr/cmd_write/cmd_wdata   command payload, latched on handshake
//   rsp_valid/rsp_ready            response handshake
//   rsp_rdata/rsp_err              read data (0 for writes), error flag
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA  APB3 master outputs
//   PRDATA/PREADY/PSLVERR          APB3 slave returns
module apb_cmd_master #(
    parameter int unsigned P_TIMEOUT  = 16,
    parameter logic [31:0] P_ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_addr,
    input  logic        cmd_write,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);

    // Wide enough to hold P_TIMEOUT itself, so the count never wraps.
    localparam int unsigned CW =
        (P_TIMEOUT == 0) ? 1 : $clog2(P_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          tmo_hit;

    logic          cmd_ready_q;
    logic          rsp_valid_q;
    logic [31:0]   rsp_rdata_q;
    logic          rsp_err_q;
    logic          psel_q;
    logic          penable_q;
    logic          pwrite_q;
    logic [31:0]   paddr_q;
    logic [31:0]   pwdata_q;

    assign cnt_d = cnt_q + CW'(1);

    // This wait cycle is the P_TIMEOUT-th one without PREADY.
    assign tmo_hit = (P_TIMEOUT != 0) && (32'(cnt_d) == P_TIMEOUT);

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        paddr_q     <= cmd_addr;
                        pwrite_q    <= cmd_write;
                        pwdata_q    <= cmd_wdata;
                        psel_q      <= 1'b1;
                        state_q     <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        rsp_rdata_q <= pwrite_q ? 32'd0 : PRDATA;
                        rsp_err_q   <= PSLVERR;
                        rsp_valid_q <= 1'b1;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= RESP;
                    end else if (tmo_hit) begin
                        // Slave never answered: abandon the transfer.
                        rsp_rdata_q <= P_ERR_DATA;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= RESP;
                    end else if (P_TIMEOUT != 0) begin
                        cnt_q <= cnt_d;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: scoreboard bench for apb_cmd_master with a
// reactive APB slave and a transaction-level reference model.
module tb_apb_cmd_master;

    localparam int          TMO  = 4;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA = '0;
    logic        PREADY = 1'b0;
    logic        PSLVERR = 1'b0;

    apb_cmd_master #(
        .P_TIMEOUT (TMO),
        .P_ERR_DATA(ERRD)
    ) dut (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_addr (cmd_addr),
        .cmd_write(cmd_write),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rr_mode  = 1;
    bit in_reset = 1'b1;

    always @(posedge PCLK) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        int          w;
        logic        err;
    } cfg_t;

    exp_t        exp_q[$];
    cfg_t        cfg_q[$];
    int          hs_q[$];
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] slv_mem[logic [31:0]];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic summary();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " PSEL"}, 32'(PSEL), 0);
        chk({tag, " PENABLE"}, 32'(PENABLE), 0);
        chk({tag, " PWRITE"}, 32'(PWRITE), 0);
        chk({tag, " PADDR"}, PADDR, 0);
        chk({tag, " PWDATA"}, PWDATA, 0);
        chk({tag, " rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, " rsp_rdata"}, rsp_rdata, 0);
        chk({tag, " rsp_err"}, 32'(rsp_err), 0);
        chk({tag, " cmd_ready"}, 32'(cmd_ready), 0);
    endtask

    // Reference model: outcome of a command from the transfer rules alone.
    task automatic do_cmd(input logic [31:0] a, input logic wr,
                          input logic [31:0] d, input int w,
                          input logic e);
        exp_t x;
        cfg_t c;
        bit   ok;
        bit   tmo;
        tmo = (w >= TMO);
        if (tmo) begin
            x.rdata = ERRD;
            x.err   = 1'b1;
            x.lat   = 2 + TMO;
        end else begin
            x.err = e;
            x.lat = 3 + w;
            if (wr) begin
                x.rdata = 32'd0;
                if (!e) ref_mem[a] = d;
            end else begin
                x.rdata = ref_mem.exists(a) ? ref_mem[a] : 32'd0;
            end
        end
        exp_q.push_back(x);
        c.addr  = a;
        c.wr    = wr;
        c.wdata = d;
        c.w     = w;
        c.err   = e;
        cfg_q.push_back(c);
        @(negedge PCLK);
        cmd_addr  = a;
        cmd_write = wr;
        cmd_wdata = d;
        cmd_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (cmd_ready === 1'b1) begin
                hs_q.push_back(cyc);
                ok = 1'b1;
                break;
            end
            @(negedge PCLK);
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL cmd_accept: got no cmd_ready expected handshake");
            summary();
            $fatal(1, "command never accepted");
        end
        @(posedge PCLK);
        #1;
        cmd_valid = 1'b0;
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        cmd_write = 1'($urandom);
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
            @(negedge PCLK);
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
    endtask

    // Response back-pressure driver.
    initial begin
        forever begin
            @(posedge PCLK);
            #1;
            case (rr_mode)
                0: rsp_ready = ($urandom % 3) != 0;
                1: rsp_ready = 1'b1;
                default: rsp_ready = 1'b0;
            endcase
        end
    end

    // Reactive APB slave with per-command wait states and error.
    initial begin
        cfg_t cur;
        bit   act;
        int   wc;
        act = 1'b0;
        wc  = 0;
        cur = '{default: '0};
        forever begin
            @(negedge PCLK);
            PRDATA  = $urandom;
            PSLVERR = 1'($urandom);
            PREADY  = 1'($urandom);
            if (PSEL === 1'b1 && PENABLE === 1'b0) begin
                if (cfg_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL setup: got unexpected SETUP expected none");
                end else begin
                    cur = cfg_q.pop_front();
                    act = 1'b1;
                    wc  = 0;
                    chk("setup PADDR", PADDR, cur.addr);
                    chk("setup PWRITE", 32'(PWRITE), 32'(cur.wr));
                    chk("setup PWDATA", PWDATA, cur.wdata);
                end
            end else if (PSEL === 1'b1 && PENABLE === 1'b1) begin
                if (!act) begin
                    checks++;
                    failures++;
                    $display("FAIL access: got extra ACCESS expected idle bus");
                end else begin
                    chk("access PADDR", PADDR, cur.addr);
                    chk("access PWRITE", 32'(PWRITE), 32'(cur.wr));
                    chk("access PWDATA", PWDATA, cur.wdata);
                    if (wc == cur.w) begin
                        PREADY  = 1'b1;
                        PSLVERR = cur.err;
                        if (cur.wr) begin
                            if (!cur.err) slv_mem[cur.addr] = cur.wdata;
                        end else begin
                            PRDATA = slv_mem.exists(cur.addr) ?
                                     slv_mem[cur.addr] : 32'd0;
                        end
                        act = 1'b0;
                    end else begin
                        PREADY = 1'b0;
                        wc++;
                    end
                end
            end
        end
    end

    // Response monitor: pops the scoreboard on each new response.
    initial begin
        exp_t cur;
        bit   seen;
        int   hs;
        seen = 1'b0;
        cur  = '{default: '0};
        forever begin
            @(negedge PCLK);
            if (!in_reset && rsp_valid === 1'b1) begin
                if (!seen) begin
                    if (exp_q.size() == 0 || hs_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL rsp: got unexpected response %h",
                                 rsp_rdata);
                    end else begin
                        cur = exp_q.pop_front();
                        hs  = hs_q.pop_front();
                        chk("rsp_rdata", rsp_rdata, cur.rdata);
                        chk("rsp_err", 32'(rsp_err), 32'(cur.err));
                        chk("rsp latency", 32'(cyc - hs), 32'(cur.lat));
                        chk("rsp PSEL", 32'(PSEL), 0);
                        chk("rsp cmd_ready", 32'(cmd_ready), 0);
                    end
                    seen = 1'b1;
                end else begin
                    chk("hold rsp_rdata", rsp_rdata, cur.rdata);
                    chk("hold rsp_err", 32'(rsp_err), 32'(cur.err));
                    chk("hold cmd_ready", 32'(cmd_ready), 0);
                end
                if (rsp_ready) seen = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        summary();
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          r;
        int          w;
        bit          got;

        repeat (3) @(negedge PCLK);
        chk_reset_outputs("reset");
        PRESETn = 1'b1;
        @(negedge PCLK);
        chk("ready after reset", 32'(cmd_ready), 1);
        in_reset = 1'b0;

        rr_mode = 1;
        do_cmd(32'h10, 1'b1, 32'hA5A5_1234, 0, 1'b0);
        do_cmd(32'h10, 1'b0, $urandom, 0, 1'b0);
        do_cmd(32'h20, 1'b1, 32'h0BAD_F00D, 0, 1'b0);
        do_cmd(32'h20, 1'b0, $urandom, 3, 1'b0);
        do_cmd(32'h20, 1'b0, $urandom, 0, 1'b1);
        do_cmd(32'h30, 1'b0, $urandom, TMO, 1'b0);
        do_cmd(32'h30, 1'b1, 32'h1111_2222, TMO + 3, 1'b0);
        do_cmd(32'h30, 1'b0, $urandom, 1, 1'b0);
        drain();

        // Stalled response consumer.
        rr_mode = 2;
        do_cmd(32'h10, 1'b0, $urandom, 0, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge PCLK);
            if (rsp_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        chk("stall rsp seen", 32'(got), 1);
        repeat (5) begin
            @(negedge PCLK);
            chk("stall rsp_valid", 32'(rsp_valid), 1);
            chk("stall cmd_ready", 32'(cmd_ready), 0);
        end
        rr_mode = 1;
        do_cmd(32'h20, 1'b0, $urandom, 0, 1'b0);
        drain();

        rr_mode = 0;
        repeat (300) begin
            a = 32'($urandom_range(0, 15)) * 32'd4;
            r = $urandom_range(0, 9);
            if (r < 6) w = $urandom_range(0, 2);
            else if (r < 8) w = 3;
            else w = $urandom_range(TMO, TMO + 2);
            repeat ($urandom_range(0, 2)) @(negedge PCLK);
            do_cmd(a, 1'($urandom), $urandom, w, ($urandom % 6) == 0);
        end
        drain();

        // Reset pulse in the middle of an ACCESS phase.
        rr_mode = 1;
        do_cmd(32'h44, 1'b1, 32'h1234_5678, 20, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge PCLK);
            if (PSEL === 1'b1 && PENABLE === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        chk("access reached", 32'(got), 1);
        PRESETn  = 1'b0;
        in_reset = 1'b1;
        @(negedge PCLK);
        chk_reset_outputs("midreset");
        exp_q.delete();
        hs_q.delete();
        cfg_q.delete();
        PRESETn = 1'b1;
        @(negedge PCLK);
        chk("midreset ready", 32'(cmd_ready), 1);
        chk("midreset no rsp", 32'(rsp_valid), 0);
        in_reset = 1'b0;
        do_cmd(32'h10, 1'b0, $urandom, 0, 1'b0);
        do_cmd(32'h44, 1'b0, $urandom, 2, 1'b0);
        drain();

        summary();
        $finish;
    end

endmodule
